// File: rtl/decode_stage_if.sv
// decode_stage_if
// Groups the D pipeline register inputs, the E/M/W forwarding sources, the
// W-stage register-file write port, the bubble control, the combinational
// source IDs and the E pipeline register outputs of the decode stage.
//   slave  : the decode stage's view (D/fwd/W/bubble in, d_src*/E_* out)
//   master : the driving environment's view (mirror image of slave)
interface decode_stage_if;
   logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic [1:0]  D_stat;
   logic [3:0]  e_dstE;
   logic [63:0] e_valE;
   logic [3:0]  M_dstE, M_dstM;
   logic [63:0] M_valE, m_valM;
   logic [3:0]  W_dstE, W_dstM;
   logic [63:0] W_valE, W_valM;
   logic        E_bubble;
   logic [3:0]  d_srcA, d_srcB;
   logic [3:0]  E_icode, E_ifun;
   logic [63:0] E_valC, E_valA, E_valB;
   logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
   logic [1:0]  E_stat;

   modport slave (
      input  D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
      input  e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
      input  W_dstE, W_dstM, W_valE, W_valM, E_bubble,
      output d_srcA, d_srcB,
      output E_icode, E_ifun, E_valC, E_valA, E_valB,
      output E_dstE, E_dstM, E_srcA, E_srcB, E_stat
   );

   modport master (
      output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
      output e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
      output W_dstE, W_dstM, W_valE, W_valM, E_bubble,
      input  d_srcA, d_srcB,
      input  E_icode, E_ifun, E_valC, E_valA, E_valB,
      input  E_dstE, E_dstM, E_srcA, E_srcB, E_stat
   );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
// Decode / write-back stage of the pipelined Y86-64 core. Decodes the D
// register into source/destination register IDs, reads operands from the
// 15 x 64-bit register file (written from W), optionally forwards operands
// from the e/M/W stages, and loads the E pipeline register.
// Ports:
//   clk    : stage clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset (clears rf, loads bubble into E)
//   bus    : decode_stage_if.slave (D inputs, forwarding sources, W write
//            port, E_bubble, d_srcA/d_srcB, E register outputs)
// Configuration macro:
//   DECODE_FWD_EN : when defined, valA/valB use the e/M/W forwarding chain;
//                   otherwise operands come from the register file only.
module decode_stage #(
   parameter logic [3:0] RNONE = 4'hF,
   parameter logic [3:0] RRSP  = 4'h4
) (
   input logic          clk,
   input logic          rst_n,
   decode_stage_if.slave bus
);

   logic [63:0] rf [0:14];
   logic [3:0]  src_a, src_b, dst_e, dst_m;
   logic [63:0] rf_a, rf_b, val_a, val_b;

   // Register IDs derived from the instruction code
   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (bus.D_icode)
         4'h2, 4'h4, 4'h6, 4'hA: src_a = bus.D_rA;
         4'h9, 4'hB:             src_a = RRSP;
         default:                src_a = RNONE;
      endcase
      case (bus.D_icode)
         4'h4, 4'h5, 4'h6:       src_b = bus.D_rB;
         4'h8, 4'h9, 4'hA, 4'hB: src_b = RRSP;
         default:                src_b = RNONE;
      endcase
      case (bus.D_icode)
         4'h2, 4'h3, 4'h6:       dst_e = bus.D_rB;
         4'h8, 4'h9, 4'hA, 4'hB: dst_e = RRSP;
         default:                dst_e = RNONE;
      endcase
      case (bus.D_icode)
         4'h5, 4'hB:             dst_m = bus.D_rA;
         default:                dst_m = RNONE;
      endcase
   end

   assign bus.d_srcA = src_a;
   assign bus.d_srcB = src_b;

   // Register 15 has no storage, so its reads are tied to zero
   assign rf_a = (src_a == 4'hF) ? 64'd0 : rf[src_a];
   assign rf_b = (src_b == 4'hF) ? 64'd0 : rf[src_b];

   // Operand selection; call/jump carry the return address in valA, and a
   // missing source always reads as zero so it never picks up a forward
   always_comb begin
      val_a = 64'd0;
      if (bus.D_icode == 4'h7 || bus.D_icode == 4'h8)
         val_a = bus.D_valP;
      else if (src_a == RNONE)
         val_a = 64'd0;
`ifdef DECODE_FWD_EN
      else if (src_a == bus.e_dstE) val_a = bus.e_valE;
      else if (src_a == bus.M_dstM) val_a = bus.m_valM;
      else if (src_a == bus.M_dstE) val_a = bus.M_valE;
      else if (src_a == bus.W_dstM) val_a = bus.W_valM;
      else if (src_a == bus.W_dstE) val_a = bus.W_valE;
`endif
      else
         val_a = rf_a;
   end

   always_comb begin
      val_b = 64'd0;
      if (src_b == RNONE)
         val_b = 64'd0;
`ifdef DECODE_FWD_EN
      else if (src_b == bus.e_dstE) val_b = bus.e_valE;
      else if (src_b == bus.M_dstM) val_b = bus.m_valM;
      else if (src_b == bus.M_dstE) val_b = bus.M_valE;
      else if (src_b == bus.W_dstM) val_b = bus.W_valM;
      else if (src_b == bus.W_dstE) val_b = bus.W_valE;
`endif
      else
         val_b = rf_b;
   end

`ifndef DECODE_FWD_EN
   // Without forwarding the e/M sources are architecturally ignored
   logic unused_fwd;
   assign unused_fwd = ^{bus.e_dstE, bus.e_valE, bus.M_dstE, bus.M_dstM,
                         bus.M_valE, bus.m_valM};
`endif

   // Register file: the M port is written last so popq %rsp keeps the
   // loaded value when both ports name the same register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) rf[i] <= 64'd0;
      end else begin
         if (bus.W_dstE != RNONE && bus.W_dstE != 4'hF)
            rf[bus.W_dstE] <= bus.W_valE;
         if (bus.W_dstM != RNONE && bus.W_dstM != 4'hF)
            rf[bus.W_dstM] <= bus.W_valM;
      end
   end

   // E pipeline register; reset and bubble both insert a nop
   always_ff @(posedge clk) begin
      if (!rst_n || bus.E_bubble) begin
         bus.E_icode <= 4'h1;
         bus.E_ifun  <= 4'h0;
         bus.E_valC  <= 64'd0;
         bus.E_valA  <= 64'd0;
         bus.E_valB  <= 64'd0;
         bus.E_dstE  <= RNONE;
         bus.E_dstM  <= RNONE;
         bus.E_srcA  <= RNONE;
         bus.E_srcB  <= RNONE;
         bus.E_stat  <= 2'd0;
      end else begin
         bus.E_icode <= bus.D_icode;
         bus.E_ifun  <= bus.D_ifun;
         bus.E_valC  <= bus.D_valC;
         bus.E_valA  <= val_a;
         bus.E_valB  <= val_b;
         bus.E_dstE  <= dst_e;
         bus.E_dstM  <= dst_m;
         bus.E_srcA  <= src_a;
         bus.E_srcB  <= src_b;
         bus.E_stat  <= bus.D_stat;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic, compared against a behavioural model that keeps its
// own copy of the register file and the forwarding priority list.
module tb_decode_stage;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [63:0] m_rf [16];

   decode_stage_if bus ();

   decode_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] modelSrcA(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] modelSrcB(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] modelDstE(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] modelDstM(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return 4'hF;
   endfunction

   // Operand value: zero for no register, otherwise the first entry in the
   // forwarding priority list naming this register, otherwise the rf copy
   function automatic logic [63:0] modelOperand(input logic [3:0] src);
      logic [3:0]  fdst [5];
      logic [63:0] fval [5];
      if (src == 4'hF) return 64'd0;
`ifdef DECODE_FWD_EN
      fdst = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
      fval = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
      for (int i = 0; i < 5; i++)
         if (fdst[i] == src) return fval[i];
`else
      fdst = '{default: 4'hF};
      fval = '{default: 64'd0};
      if (fdst[0] != 4'hF) return fval[0];
`endif
      return m_rf[src];
   endfunction

   // Checks the combinational source IDs, advances one clock and checks
   // the E register against the model; the model rf is updated on the way
   task automatic applyStimulus();
      logic [3:0]  sa, sb, de, dm, xic, xif;
      logic [63:0] va, vb, vc;
      logic [1:0]  st;
      #1;
      sa = modelSrcA(bus.D_icode, bus.D_rA);
      sb = modelSrcB(bus.D_icode, bus.D_rB);
      checkOutput("d_srcA", 64'(bus.d_srcA), 64'(sa));
      checkOutput("d_srcB", 64'(bus.d_srcB), 64'(sb));
      if (!rst_n || bus.E_bubble) begin
         xic = 4'h1; xif = 4'h0; vc = 64'd0; va = 64'd0; vb = 64'd0;
         de = 4'hF; dm = 4'hF; sa = 4'hF; sb = 4'hF; st = 2'd0;
      end else begin
         xic = bus.D_icode; xif = bus.D_ifun; vc = bus.D_valC; st = bus.D_stat;
         de = modelDstE(bus.D_icode, bus.D_rB);
         dm = modelDstM(bus.D_icode, bus.D_rA);
         va = (bus.D_icode inside {4'h7, 4'h8}) ? bus.D_valP : modelOperand(sa);
         vb = modelOperand(sb);
      end
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_rf[i] = 64'd0;
      end else begin
         if (bus.W_dstE != 4'hF) m_rf[bus.W_dstE] = bus.W_valE;
         if (bus.W_dstM != 4'hF) m_rf[bus.W_dstM] = bus.W_valM;
      end
      @(posedge clk);
      #1;
      checkOutput("E_icode", 64'(bus.E_icode), 64'(xic));
      checkOutput("E_ifun",  64'(bus.E_ifun),  64'(xif));
      checkOutput("E_valC",  bus.E_valC, vc);
      checkOutput("E_valA",  bus.E_valA, va);
      checkOutput("E_valB",  bus.E_valB, vb);
      checkOutput("E_dstE",  64'(bus.E_dstE), 64'(de));
      checkOutput("E_dstM",  64'(bus.E_dstM), 64'(dm));
      checkOutput("E_srcA",  64'(bus.E_srcA), 64'(sa));
      checkOutput("E_srcB",  64'(bus.E_srcB), 64'(sb));
      checkOutput("E_stat",  64'(bus.E_stat), 64'(st));
   endtask

   task automatic clearSide();
      bus.e_dstE = 4'hF; bus.M_dstE = 4'hF; bus.M_dstM = 4'hF;
      bus.W_dstE = 4'hF; bus.W_dstM = 4'hF; bus.E_bubble = 1'b0;
   endtask

   task automatic setInstr(input logic [3:0] ic, input logic [3:0] ra,
                           input logic [3:0] rb);
      bus.D_icode = ic; bus.D_ifun = 4'h0; bus.D_rA = ra; bus.D_rB = rb;
      bus.D_valC = 64'h0; bus.D_valP = 64'h0; bus.D_stat = 2'd0;
   endtask

   function automatic logic [3:0] randReg();
      if ($urandom_range(0, 3) == 0) return 4'hF;
      return 4'($urandom_range(0, 7));
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) m_rf[i] = 64'd0;
      bus.e_valE = 64'd0; bus.M_valE = 64'd0; bus.m_valM = 64'd0;
      bus.W_valE = 64'd0; bus.W_valM = 64'd0;
      clearSide();
      setInstr(4'h6, 4'h1, 4'h2);

      // Reset with a pending W write
      rst_n = 1'b0;
      bus.W_dstE = 4'h3; bus.W_valE = 64'd55;
      bus.E_bubble = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("rst_icode", 64'(bus.E_icode), 64'h1);
      checkOutput("rst_dstE",  64'(bus.E_dstE),  64'hF);
      rst_n = 1'b1;
      clearSide();
      setInstr(4'h6, 4'h3, 4'h3);
      applyStimulus();
      checkOutput("rst_rf3", bus.E_valA, 64'd0);

      // Write-back then read
      setInstr(4'h1, 4'hF, 4'hF);
      bus.W_dstE = 4'h2; bus.W_valE = 64'd100;
      applyStimulus();
      clearSide();
      setInstr(4'h6, 4'h2, 4'h2);
      applyStimulus();
      checkOutput("wb_valA", bus.E_valA, 64'd100);
      checkOutput("wb_valB", bus.E_valB, 64'd100);
      checkOutput("wb_dstE", 64'(bus.E_dstE), 64'd2);

      // Forwarding priority
      setInstr(4'h2, 4'h5, 4'h1);
      bus.e_dstE = 4'h5; bus.e_valE = 64'd7;
      bus.M_dstE = 4'h5; bus.M_valE = 64'd8;
      bus.W_dstE = 4'h5; bus.W_valE = 64'd9;
      applyStimulus();
`ifdef DECODE_FWD_EN
      checkOutput("fwd_e", bus.E_valA, 64'd7);
`else
      checkOutput("fwd_e", bus.E_valA, 64'd0);
`endif
      bus.e_dstE = 4'hF;
      applyStimulus();
`ifdef DECODE_FWD_EN
      checkOutput("fwd_M", bus.E_valA, 64'd8);
`else
      checkOutput("fwd_M", bus.E_valA, 64'd9);
`endif
      clearSide();

      // Call
      setInstr(4'h1, 4'hF, 4'hF);
      bus.W_dstE = 4'h4; bus.W_valE = 64'h200;
      applyStimulus();
      clearSide();
      setInstr(4'h8, 4'hF, 4'hF);
      bus.D_valP = 64'h40;
      applyStimulus();
      checkOutput("call_valA", bus.E_valA, 64'h40);
      checkOutput("call_valB", bus.E_valB, 64'h200);
      checkOutput("call_dstE", 64'(bus.E_dstE), 64'h4);
      checkOutput("call_srcA", 64'(bus.E_srcA), 64'hF);

      // popq %rsp: M port wins
      setInstr(4'h1, 4'hF, 4'hF);
      bus.W_dstE = 4'h4; bus.W_valE = 64'h108;
      bus.W_dstM = 4'h4; bus.W_valM = 64'h77;
      applyStimulus();
      clearSide();
      setInstr(4'h6, 4'h4, 4'h4);
      applyStimulus();
      checkOutput("popq_rsp", bus.E_valA, 64'h77);

      // Bubble with a simultaneous write-back
      setInstr(4'h3, 4'h1, 4'h1);
      bus.D_stat = 2'd2;
      bus.E_bubble = 1'b1;
      bus.W_dstE = 4'h1; bus.W_valE = 64'h1234;
      applyStimulus();
      checkOutput("bub_icode", 64'(bus.E_icode), 64'h1);
      checkOutput("bub_dstE",  64'(bus.E_dstE),  64'hF);
      checkOutput("bub_stat",  64'(bus.E_stat),  64'h0);
      clearSide();
      setInstr(4'h6, 4'h1, 4'h1);
      applyStimulus();
      checkOutput("bub_wb", bus.E_valA, 64'h1234);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst_n        = ($urandom_range(0, 59) != 0);
         bus.D_icode  = 4'($urandom_range(0, 15));
         bus.D_ifun   = 4'($urandom_range(0, 15));
         bus.D_rA     = randReg();
         bus.D_rB     = randReg();
         bus.D_valC   = {$urandom, $urandom};
         bus.D_valP   = {$urandom, $urandom};
         bus.D_stat   = 2'($urandom_range(0, 3));
         bus.e_dstE   = randReg();  bus.e_valE = {$urandom, $urandom};
         bus.M_dstE   = randReg();  bus.M_valE = {$urandom, $urandom};
         bus.M_dstM   = randReg();  bus.m_valM = {$urandom, $urandom};
         bus.W_dstE   = randReg();  bus.W_valE = {$urandom, $urandom};
         bus.W_dstM   = randReg();  bus.W_valM = {$urandom, $urandom};
         bus.E_bubble = ($urandom_range(0, 7) == 0);
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
